// File: rtl/demux4_dispatch_ctrl.sv
// Single-word buffered dispatch controller for a 1:4 demux (round-robin or fixed target).
// Optional per-destination delivery counters are enabled by defining DISPATCH_COUNT_EN.
module demux4_dispatch_ctrl #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic [1:0]        fix_sel,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic [1:0]        dmx_sel,
  output logic              dmx_en,
  output logic              busy,
  output logic              timeout
`ifdef DISPATCH_COUNT_EN
  ,
  output logic [31:0]       cnt_out
`endif
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      state;
  logic [1:0]      target;
  logic [1:0]      rr_ptr;
  logic [1:0]      rr_ptr_next;
  logic [1:0]      target_inc;
  logic [1:0]      cap_target;
  logic [TO_W-1:0] stall_cnt;
  logic            fire;
  logic            capture;
  logic            stall_hit;

  assign busy       = (state == ST_FULL);
  assign fire       = busy & out_ready[target];
  // Combinational from out_ready so a draining buffer can refill in the same cycle.
  assign in_ready   = ~busy | fire;
  assign capture    = in_valid & in_ready;
  assign target_inc = target + 2'd1;

  // The pointer must already reflect a delivery happening this cycle so that
  // back-to-back words in round-robin mode walk 0,1,2,3 without repeats.
  assign rr_ptr_next = (fire && !mode) ? target_inc : rr_ptr;
  assign cap_target  = mode ? fix_sel : rr_ptr_next;

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign stall_hit = 1'b0;
    end else begin : g_timeout
      assign stall_hit = busy & ~fire & (stall_cnt == TO_W'(TIMEOUT - 1));
    end
  endgenerate

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      target    <= 2'd0;
      rr_ptr    <= 2'd0;
      stall_cnt <= '0;
      out_data  <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= stall_hit;

      if (fire && !mode) begin
        rr_ptr <= target_inc;
      end

      if (capture) begin
        out_data <= in_data;
        target   <= cap_target;
        state    <= ST_FULL;
      end else if (fire) begin
        state <= ST_EMPTY;
      end else if (stall_hit && !mode) begin
        // Stuck consumer in round-robin mode: offer the same word to the next one.
        target <= target_inc;
      end

      if (!busy || fire || stall_hit || (TIMEOUT == 0)) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + TO_W'(1);
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    out_valid = 4'b0000;
    if (busy) begin
      out_valid = 4'b0001 << target;
    end
  end

  // target only changes on capture or retarget, so it naturally holds the last select when empty.
  assign dmx_sel = target;
  assign dmx_en  = busy;

`ifdef DISPATCH_COUNT_EN
  logic [7:0] disp_cnt [4];

  // NOTE: the counter array is tiny and visible on a port, so it is reset like any other register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        disp_cnt[i] <= 8'd0;
      end
    end else if (fire) begin
      disp_cnt[target] <= disp_cnt[target] + 8'd1;
    end
  end

  assign cnt_out = {disp_cnt[3], disp_cnt[2], disp_cnt[1], disp_cnt[0]};
`endif

endmodule

// File: tb/tb_demux4_dispatch_ctrl.sv
// Scoreboard bench for demux4_dispatch_ctrl: expected (destination, word) pairs are
// queued when a word is offered and compared when the demux delivers it.
module tb_demux4_dispatch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] fix_sel;
  logic       in_valid;
  logic [7:0] in_data;
  logic [3:0] out_ready;

  logic       in_ready,  in_ready_3;
  logic [7:0] out_data,  out_data_3;
  logic [3:0] out_valid, out_valid_3;
  logic [1:0] dmx_sel,   dmx_sel_3;
  logic       dmx_en,    dmx_en_3;
  logic       busy,      busy_3;
  logic       timeout,   timeout_3;
`ifdef DISPATCH_COUNT_EN
  logic [31:0] cnt_out, cnt_out_3;
`endif

  typedef struct packed {
    logic [1:0] dest;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b1;

  always #5 clk = ~clk;

  demux4_dispatch_ctrl #(.DATA_W(8), .TIMEOUT(15), .TO_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .fix_sel(fix_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .dmx_sel(dmx_sel), .dmx_en(dmx_en), .busy(busy), .timeout(timeout)
`ifdef DISPATCH_COUNT_EN
    , .cnt_out(cnt_out)
`endif
  );

  demux4_dispatch_ctrl #(.DATA_W(8), .TIMEOUT(3), .TO_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .fix_sel(fix_sel),
    .in_valid(in_valid), .in_ready(in_ready_3), .in_data(in_data),
    .out_data(out_data_3), .out_valid(out_valid_3), .out_ready(out_ready),
    .dmx_sel(dmx_sel_3), .dmx_en(dmx_en_3), .busy(busy_3), .timeout(timeout_3)
`ifdef DISPATCH_COUNT_EN
    , .cnt_out(cnt_out_3)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word and hold it until accepted, bounded by a cycle budget.
  task automatic send(input logic [7:0] d);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && waited < 64) begin
      tick();
      waited++;
    end
    if (!in_ready) check("send_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // A delivery happens at the next rising edge whenever valid meets ready; sample on the falling edge.
  always @(negedge clk) begin
    if (mon_en && rst_n && ((out_valid & out_ready) != 4'b0000)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_dlv", {28'd0, out_valid & out_ready}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("dlv_valid", {28'd0, out_valid}, {28'd0, 4'b0001 << e.dest});
        check("dlv_sel",   {30'd0, dmx_sel},   {30'd0, e.dest});
        check("dlv_data",  {24'd0, out_data},  {24'd0, e.data});
        check("dlv_en",    {31'd0, dmx_en},    32'd1);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int first_pulse;
    int second_pulse;
    int bad;
    mode    = 1'b0;
    fix_sel = 2'd0;
    do_reset();

    // Reset state
    check("rst_out_valid", {28'd0, out_valid}, 32'd0);
    check("rst_dmx_sel",   {30'd0, dmx_sel},   32'd0);
    check("rst_dmx_en",    {31'd0, dmx_en},    32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_timeout",   {31'd0, timeout},   32'd0);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Round-robin, all ready, six words back-to-back
    mode      = 1'b0;
    out_ready = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back({2'(i % 4), 8'(8'h11 + i)});
    end
    for (int i = 0; i < 6; i++) begin
      check("rr_in_ready", {31'd0, in_ready}, 32'd1);
      send(8'(8'h11 + i));
    end
    tick();
    check("rr_drained", sb_q.size(), 32'd0);
    check("rr_empty", {31'd0, busy}, 32'd0);

    // Fixed dispatch to destination 2; round-robin pointer must stay at 2
    mode      = 1'b1;
    fix_sel   = 2'd2;
    out_ready = 4'b0100;
    sb_q.push_back({2'd2, 8'hA0});
    sb_q.push_back({2'd2, 8'hA1});
    send(8'hA0);
    check("fix_out_valid", {28'd0, out_valid}, 32'h4);
    check("fix_dmx_sel",   {30'd0, dmx_sel},   32'd2);
    check("fix_dmx_en",    {31'd0, dmx_en},    32'd1);
    check("fix_busy",      {31'd0, busy},      32'd1);
    send(8'hA1);
    tick();
    mode = 1'b0;
    sb_q.push_back({2'd2, 8'hB0});
    send(8'hB0);
    tick();
    check("fix_drained", sb_q.size(), 32'd0);

    // Stall timeout with TIMEOUT=3 in round-robin mode: retarget from 0 to 1
    mon_en = 1'b0;
    do_reset();
    mode      = 1'b0;
    out_ready = 4'b1110;
    send(8'h5C);
    check("to3_valid0", {28'd0, out_valid_3}, 32'h1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("to3_no_pulse", {31'd0, timeout_3}, 32'd0);
      check("to3_hold",     {28'd0, out_valid_3}, 32'h1);
    end
    tick();
    check("to3_pulse",    {31'd0, timeout_3},   32'd1);
    check("to3_retarget", {28'd0, out_valid_3}, 32'h2);
    check("to3_sel",      {30'd0, dmx_sel_3},   32'd1);
    check("to3_data",     {24'd0, out_data_3},  32'h5C);
    tick();
    check("to3_pulse_end", {31'd0, timeout_3},   32'd0);
    check("to3_delivered", {31'd0, busy_3},      32'd0);
    check("to3_valid_off", {28'd0, out_valid_3}, 32'd0);
    do_reset();
    mon_en = 1'b1;

    // Fixed target 3 with no consumer ready: periodic timeouts, word held
    mode      = 1'b1;
    fix_sel   = 2'd3;
    out_ready = 4'b0000;
    sb_q.push_back({2'd3, 8'h3C});
    send(8'h3C);
    pulses = 0; first_pulse = -1; second_pulse = -1; bad = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (timeout) begin
        pulses++;
        if (first_pulse < 0) first_pulse = k;
        else if (second_pulse < 0) second_pulse = k;
      end
      if (dmx_sel != 2'd3 || in_ready != 1'b0 || out_valid != 4'b1000) bad++;
    end
    check("fixto_pulses", pulses,       32'd2);
    check("fixto_first",  first_pulse,  32'd15);
    check("fixto_second", second_pulse, 32'd30);
    check("fixto_hold",   bad,          32'd0);
    out_ready = 4'b1000;
    tick();
    tick();
    check("fixto_drained", sb_q.size(), 32'd0);
    check("fixto_empty",   {31'd0, busy}, 32'd0);

    // Reset while holding a word discards it
    mode      = 1'b0;
    out_ready = 4'b0000;
    send(8'h7E);
    tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", {28'd0, out_valid}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},      32'd0);
    check("mid_rst_en",    {31'd0, dmx_en},    32'd0);
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    repeat (3) tick();
    check("mid_rst_none", sb_q.size(), 32'd0);

`ifdef DISPATCH_COUNT_EN
    // 300 round-robin words: every destination counter reaches 75
    do_reset();
    mode      = 1'b0;
    out_ready = 4'b1111;
    for (int i = 0; i < 300; i++) begin
      sb_q.push_back({2'(i % 4), 8'(i)});
    end
    for (int i = 0; i < 300; i++) begin
      send(8'(i));
    end
    tick();
    check("cnt_drained", sb_q.size(), 32'd0);
    check("cnt_out", cnt_out, {8'd75, 8'd75, 8'd75, 8'd75});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux4_dispatch_ctrl.md
Name: demux4_dispatch_ctrl

Overview:
Sequencing controller for the 1:4 demultiplexer datapath (select pair S1:S0 plus enable). Accepts a word stream over a valid/ready handshake and buffers one word. Drives the demux select/enable so each word reaches exactly one of four destinations, either round-robin or by a fixed select. Sits between a single producer and four consumers that each have their own ready.

Parameters:
DATA_W, 8, width of data word routed through the demux
TIMEOUT, 15, stall cycles before timeout action; 0 disables timeout
TO_W, 4, width of stall counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = round-robin dispatch, 1 = fixed dispatch via fix_sel
fix_sel  input  2  destination index used when mode=1 (bit1=S1, bit0=S0)
in_valid  input  1  producer has a word
in_ready  output  1  controller accepts word this cycle
in_data  input  DATA_W  producer word
out_data  output  DATA_W  buffered word presented to demux data input
out_valid  output  4  one-hot valid per destination
out_ready  input  4  per-destination ready
dmx_sel  output  2  demux select (S1:S0) = current target
dmx_en  output  1  demux enable, high while a word is held
busy  output  1  buffer full
timeout  output  1  one-cycle pulse on stall timeout

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low, sampled on rising clk only.
- Reset values: buffer empty, target=0, rr_ptr=0, stall_cnt=0, out_data=0, out_valid=0000, dmx_sel=00, dmx_en=0, busy=0, timeout=0. Reset mid-transfer discards the held word; no output valid the following cycle.
- State machine, two states:
  - EMPTY: in_ready=1. On in_valid, capture in_data into out_data, latch target, go to FULL.
  - FULL: hold word. fire = out_ready[target]. On fire, deliver the word. If in_valid the same cycle, capture the next word and stay FULL (back-to-back, 1 word/cycle); otherwise go to EMPTY.
- in_ready = !busy | fire. This is a combinational path from out_ready.
- Latency: accept at edge N -> out_valid visible after edge N; earliest delivery is edge N+1.
- Outputs in FULL: out_valid = onehot(target); dmx_sel = target; dmx_en = 1; busy = 1. In EMPTY: out_valid=0000, dmx_en=0, dmx_sel holds last value.
- Target selection at capture:
  - mode=1: target = fix_sel.
  - mode=0: target = rr_ptr_next, where rr_ptr_next = target+1 (mod 4) if fire in RR mode this cycle, else rr_ptr.
- rr_ptr updates to target+1 (mod 4) on every fire while mode=0; it is unchanged on fire in mode=1.
- mode/fix_sel changes while FULL affect only the next capture.
- Stall counter:
  - Increments each FULL cycle without fire; clears on fire and in EMPTY.
  - When stall_cnt==TIMEOUT-1 with no fire: timeout=1 for one cycle, stall_cnt clears.
  - If mode=0, target also advances to target+1 (mod 4); word retained, retargeted to next destination.
  - If mode=1, target is unchanged and the word waits indefinitely.
  - fire in the same cycle as the threshold wins: no timeout.
- TIMEOUT=0: counter held at 0, timeout never asserts.
- Data is never dropped or duplicated except by reset.

Optional Feature:
DISPATCH_COUNT_EN: when defined, adds output cnt_out (4x8 bits, packed {d3,d2,d1,d0}). Each 8-bit counter increments on a fire to its destination, wraps 255->0, and resets to 0. When undefined, the port and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then RR, out_ready=1111, 6 words 0x11..0x16 back-to-back -> destinations 0,1,2,3,0,1; in_ready stays 1; one delivery per cycle after first.
- mode=1, fix_sel=2, out_ready=0100, words 0xA0,0xA1 -> both on out_valid=0100, dmx_sel=10, dmx_en=1; rr_ptr unchanged.
- RR, TIMEOUT=3, out_ready=1110, word 0x5C targeted to 0 -> timeout pulse after 3 stall cycles; word delivered to destination 1 next cycle.
- mode=1, fix_sel=3, out_ready=0000 for 40 cycles -> timeout pulses every 15 cycles, dmx_sel stays 11, in_ready=0; raise out_ready[3] -> 0x.. delivered once.
- rst_n=0 while FULL holding 0x7E -> next cycle out_valid=0000, busy=0, dmx_en=0; word never delivered.
- DISPATCH_COUNT_EN defined: 300 RR words with all ready -> cnt_out d0=d1=d2=d3=75 (each counter: 75).
